cpu_control_fsm: RTL and testbench
==================================

// Module: cpu_control_fsm
// PURPOSE
// Multi-cycle control unit on the control side of the 32-bit datapath (regfile, ALU, dmem mux).
// Owns the PC and instruction register, decodes each 32-bit instruction and sequences the
// datapath control signals through FETCH/DECODE/EXEC/MEM/WB. Resolves branches from ALU flags
// and jumps from the regfile read port.
// PARAMETERS
// PC_WIDTH   9   instruction-word address width; legal range 4..9 (JR source is 9 bits)
// CNT_WIDTH  16  retired-instruction counter width
// PORTS
// clk            in   1         rising-edge clock
// rst            in   1         asynchronous, active-high reset
// run            in   1         1 = FSM may leave FETCH; 0 = hold in FETCH
// instr          in   32        imem read data for address pc (combinational imem)
// cFlag,nFlag    in   1 each    ALU carry / negative flags (combinational from datapath)
// vFlag,zFlag    in   1 each    ALU overflow / zero flags
// rfRdData0Short in   9         regfile port-0 data [8:0], JR target
// pc             out  PC_WIDTH  instruction address
// immediate      out  16        instr[15:0] of the latched instruction
// rfRdAdrx0      out  5         rs = ir[25:21]
// rfRdAdrx1      out  5         rt = ir[20:16]
// rfWrAdrx       out  5         rd = ir[15:11]
// aluCtl         out  3         ADD=000 SUB=001 AND=010 OR=011 XOR=100 SLT=101
// rfWriteEn      out  1         regfile write strobe, WB state only
// aluBusBSel     out  1         1 = ALU B from immediate, 0 = from rt
// dmemResultSel  out  1         1 = writeback from dmem, 0 = from ALU
// regDest        out  1         1 = write rd (R-type), 0 = write rt (I-type)
// dmemWrEn       out  1         dmem write strobe, MEM state of SW only
// halted         out  1         FSM in HALT
// illegal        out  1         HALT was entered via an undefined opcode/funct
// retired        out  CNT_WIDTH instructions completed; saturates at all-ones
// BEHAVIOUR
// - Reset (async): state=FETCH, pc=0, ir=0, retired=0, halted=0, illegal=0, every strobe 0,
//   aluCtl=000, select outputs 0. Reset mid-instruction aborts it; no write completes.
// - Encoding: op=ir[31:26]. op 000000 R-type funct ir[5:0]: ADD 20 SUB 22 AND 24 OR 25
//   XOR 26 SLT 2A JR 08 (hex). I/J: ADDI 08, LW 23, SW 2B, BGT 07, J 02, HALT 3F. Else illegal.
// - FETCH: if run, ir<=instr, ->DECODE; else hold. DECODE: decode ir, register all controls.
// - Controls are registered from ir; stable from DECODE through end of instruction.
// - EXEC: ALU ops ->WB; ADDI ->WB (aluBusBSel=1, ADD, regDest=0); LW/SW ->MEM with
//   aluBusBSel=1, ADD (address = rs + zero-padded imm); BGT/J/JR resolve pc, ->FETCH.
// - MEM: SW asserts dmemWrEn one cycle ->FETCH; LW ->WB with dmemResultSel=1, regDest=0.
// - WB: rfWriteEn=1 exactly one cycle ->FETCH. R-type regDest=1.
// - pc<=pc+1 (mod 2^PC_WIDTH) on leaving DECODE for non-control-flow ops; BGT compares with
//   SUB rs-rt, taken iff !zFlag && (nFlag==vFlag) sampled in EXEC: pc<=pc+1+sext(imm)
//   truncated to PC_WIDTH; not taken pc<=pc+1. J: pc<=ir[PC_WIDTH-1:0]. JR: pc<=rfRdData0Short.
// - Latency (cycles): ALU/ADDI 4, LW 5, SW 4, BGT/J/JR 3.
// - retired +1 on each transition back to FETCH; saturates, never wraps.
// - HALT/illegal: enter HALT from DECODE, halted=1 (illegal=1 if undefined), all strobes 0,
//   pc frozen; only rst exits. run is ignored outside FETCH (instruction always completes).
// - pc wrap: pc=all-ones, non-branch -> pc=0. BGT offsets wrap modulo 2^PC_WIDTH.
// TESTING
// 1 rst mid-WB of ADD -> rfWriteEn falls same cycle; pc=0, retired=0, state FETCH.
// 2 ADD r3,r1,r2 (0x00221820), run=1 -> rfWriteEn high only in cycle 4, rfWrAdrx=3, regDest=1.
// 3 LW r5,4(r0) then SW r5,8(r0) -> LW: dmemResultSel=1 in WB, cycle 5; SW: dmemWrEn in cycle 4.
// 4 BGT at pc=2, imm=-3, flags z=0,n=0,v=0 -> pc=0; z=1 -> pc=3; PC_WIDTH=4, pc=15 ADD -> pc=0.
// 5 JR with rfRdData0Short=0x0A5 -> pc=0x0A5; opcode 0x3E -> halted=1, illegal=1, pc frozen.
// 6 run=0 for 10 cycles in FETCH -> no strobes, pc unchanged; retired saturates at 0xFFFF.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit: owns PC/IR, decodes instructions and sequences the
// datapath controls through FETCH/DECODE/EXEC/MEM/WB, with branch/jump resolution.
module cpu_control_fsm #(
  parameter int PC_WIDTH  = 9,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [31:0]          instr,
  input  logic                 cFlag,
  input  logic                 nFlag,
  input  logic                 vFlag,
  input  logic                 zFlag,
  input  logic [8:0]           rfRdData0Short,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [15:0]          immediate,
  output logic [4:0]           rfRdAdrx0,
  output logic [4:0]           rfRdAdrx1,
  output logic [4:0]           rfWrAdrx,
  output logic [2:0]           aluCtl,
  output logic                 rfWriteEn,
  output logic                 aluBusBSel,
  output logic                 dmemResultSel,
  output logic                 regDest,
  output logic                 dmemWrEn,
  output logic                 halted,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    K_ALU  = 4'd0,
    K_ADDI = 4'd1,
    K_LW   = 4'd2,
    K_SW   = 4'd3,
    K_BGT  = 4'd4,
    K_J    = 4'd5,
    K_JR   = 4'd6,
    K_HALT = 4'd7,
    K_ILL  = 4'd8
  } kind_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state, state_nxt;
  kind_t  kind, kind_nxt, dec_kind;
  logic [31:0]          ir, ir_nxt;
  logic [PC_WIDTH-1:0]  pc_nxt, pc_inc;
  logic [2:0]           alu_nxt, dec_alu;
  logic                 bsel_nxt, dsel_nxt, rdst_nxt, we_nxt, dwe_nxt;
  logic                 halted_nxt, ill_nxt, bgt_taken;
  logic [CNT_WIDTH-1:0] ret_nxt, ret_sat;

  assign immediate = ir[15:0];
  assign rfRdAdrx0 = ir[25:21];
  assign rfRdAdrx1 = ir[20:16];
  assign rfWrAdrx  = ir[15:11];

  assign pc_inc    = pc + PC_WIDTH'(1);
  assign bgt_taken = !zFlag && (nFlag == vFlag);
  assign ret_sat   = (retired == {CNT_WIDTH{1'b1}}) ? retired : retired + CNT_WIDTH'(1);

  // Instruction decode of the latched IR
  always_comb begin
    dec_kind = K_ILL;
    dec_alu  = ALU_ADD;
    case (ir[31:26])
      6'h00: begin
        case (ir[5:0])
          6'h20:   begin dec_kind = K_ALU; dec_alu = ALU_ADD; end
          6'h22:   begin dec_kind = K_ALU; dec_alu = ALU_SUB; end
          6'h24:   begin dec_kind = K_ALU; dec_alu = ALU_AND; end
          6'h25:   begin dec_kind = K_ALU; dec_alu = ALU_OR;  end
          6'h26:   begin dec_kind = K_ALU; dec_alu = ALU_XOR; end
          6'h2A:   begin dec_kind = K_ALU; dec_alu = ALU_SLT; end
          6'h08:   dec_kind = K_JR;
          default: dec_kind = K_ILL;
        endcase
      end
      6'h08:   dec_kind = K_ADDI;
      6'h23:   dec_kind = K_LW;
      6'h2B:   dec_kind = K_SW;
      6'h07:   begin dec_kind = K_BGT; dec_alu = ALU_SUB; end
      6'h02:   dec_kind = K_J;
      6'h3F:   dec_kind = K_HALT;
      default: dec_kind = K_ILL;
    endcase
  end

  // Next-state and next-value logic for every register
  always_comb begin
    state_nxt  = state;
    kind_nxt   = kind;
    ir_nxt     = ir;
    pc_nxt     = pc;
    alu_nxt    = aluCtl;
    bsel_nxt   = aluBusBSel;
    dsel_nxt   = dmemResultSel;
    rdst_nxt   = regDest;
    we_nxt     = 1'b0;
    dwe_nxt    = 1'b0;
    halted_nxt = halted;
    ill_nxt    = illegal;
    ret_nxt    = retired;
    case (state)
      S_FETCH: begin
        if (run) begin
          ir_nxt    = instr;
          state_nxt = S_DECODE;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_DECODE: begin
        kind_nxt = dec_kind;
        alu_nxt  = dec_alu;
        bsel_nxt = (dec_kind == K_ADDI) || (dec_kind == K_LW) || (dec_kind == K_SW);
        dsel_nxt = (dec_kind == K_LW);
        rdst_nxt = (dec_kind == K_ALU);
        if ((dec_kind == K_HALT) || (dec_kind == K_ILL)) begin
          state_nxt  = S_HALT;
          halted_nxt = 1'b1;
          ill_nxt    = (dec_kind == K_ILL);
        end else if ((dec_kind == K_BGT) || (dec_kind == K_J) || (dec_kind == K_JR)) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_EXEC;
          pc_nxt    = pc_inc;
        end
      end
      S_EXEC: begin
        case (kind)
          K_ALU, K_ADDI: begin state_nxt = S_WB; we_nxt = 1'b1; end
          K_LW:          state_nxt = S_MEM;
          K_SW:          begin state_nxt = S_MEM; dwe_nxt = 1'b1; end
          K_BGT: begin
            // sext(imm) truncated to PC_WIDTH is just the low immediate bits
            pc_nxt    = bgt_taken ? (pc_inc + PC_WIDTH'(ir[15:0])) : pc_inc;
            state_nxt = S_FETCH;
            ret_nxt   = ret_sat;
          end
          K_J:  begin pc_nxt = ir[PC_WIDTH-1:0]; state_nxt = S_FETCH; ret_nxt = ret_sat; end
          K_JR: begin pc_nxt = PC_WIDTH'(rfRdData0Short); state_nxt = S_FETCH; ret_nxt = ret_sat; end
          default: begin state_nxt = S_FETCH; ret_nxt = ret_sat; end
        endcase
      end
      S_MEM: begin
        if (kind == K_LW) begin
          state_nxt = S_WB;
          we_nxt    = 1'b1;
        end else begin
          state_nxt = S_FETCH;
          ret_nxt   = ret_sat;
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        ret_nxt   = ret_sat;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // State, PC/IR and registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_FETCH;
      kind          <= K_ILL;
      ir            <= 32'h0000_0000;
      pc            <= '0;
      aluCtl        <= ALU_ADD;
      aluBusBSel    <= 1'b0;
      dmemResultSel <= 1'b0;
      regDest       <= 1'b0;
      rfWriteEn     <= 1'b0;
      dmemWrEn      <= 1'b0;
      halted        <= 1'b0;
      illegal       <= 1'b0;
      retired       <= '0;
    end else begin
      state         <= state_nxt;
      kind          <= kind_nxt;
      ir            <= ir_nxt;
      pc            <= pc_nxt;
      aluCtl        <= alu_nxt;
      aluBusBSel    <= bsel_nxt;
      dmemResultSel <= dsel_nxt;
      regDest       <= rdst_nxt;
      rfWriteEn     <= we_nxt;
      dmemWrEn      <= dwe_nxt;
      halted        <= halted_nxt;
      illegal       <= ill_nxt;
      retired       <= ret_nxt;
    end
  end

  // Carry flag is part of the datapath interface but no supported branch uses it
  logic unused_ok;
  assign unused_ok = cFlag;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: a default-width instance runs a small program,
// a PC_WIDTH=4/CNT_WIDTH=4 instance covers pc wrap and retired saturation.
module tb_cpu_control_fsm;

  logic clk = 1'b0;
  logic rst, run, cflag, nflag, vflag, zflag;
  logic [8:0] rd0;
  int total = 0;
  int bad = 0;

  logic [31:0] imem_a [0:511];
  logic [31:0] imem_b [0:15];
  logic [31:0] instr_a, instr_b;

  logic [8:0]  pc_a;
  logic [15:0] imm_a;
  logic [4:0]  ra0_a, ra1_a, wa_a;
  logic [2:0]  alu_a;
  logic        we_a, bsel_a, dsel_a, rdst_a, dwe_a, halted_a, ill_a;
  logic [15:0] ret_a;

  logic [3:0]  pc_b;
  logic [15:0] imm_b;
  logic [4:0]  ra0_b, ra1_b, wa_b;
  logic [2:0]  alu_b;
  logic        we_b, bsel_b, dsel_b, rdst_b, dwe_b, halted_b, ill_b;
  logic [3:0]  ret_b;

  assign instr_a = imem_a[pc_a];
  assign instr_b = imem_b[pc_b];

  always #5 clk = ~clk;

  cpu_control_fsm dut_a (
    .clk(clk), .rst(rst), .run(run), .instr(instr_a),
    .cFlag(cflag), .nFlag(nflag), .vFlag(vflag), .zFlag(zflag), .rfRdData0Short(rd0),
    .pc(pc_a), .immediate(imm_a), .rfRdAdrx0(ra0_a), .rfRdAdrx1(ra1_a), .rfWrAdrx(wa_a),
    .aluCtl(alu_a), .rfWriteEn(we_a), .aluBusBSel(bsel_a), .dmemResultSel(dsel_a),
    .regDest(rdst_a), .dmemWrEn(dwe_a), .halted(halted_a), .illegal(ill_a), .retired(ret_a)
  );

  cpu_control_fsm #(.PC_WIDTH(4), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .run(run), .instr(instr_b),
    .cFlag(cflag), .nFlag(nflag), .vFlag(vflag), .zFlag(zflag), .rfRdData0Short(rd0),
    .pc(pc_b), .immediate(imm_b), .rfRdAdrx0(ra0_b), .rfRdAdrx1(ra1_b), .rfWrAdrx(wa_b),
    .aluCtl(alu_b), .rfWriteEn(we_b), .aluBusBSel(bsel_b), .dmemResultSel(dsel_b),
    .regDest(rdst_b), .dmemWrEn(dwe_b), .halted(halted_b), .illegal(ill_b), .retired(ret_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction of cyc cycles from FETCH, recording per-cycle strobes
  // and the control word seen in the final cycle.
  task automatic run_instr(input int cyc, output logic [7:0] we_m, output logic [7:0] dw_m,
                           output logic [10:0] ctl);
    we_m = 8'h00;
    dw_m = 8'h00;
    ctl  = 11'h000;
    for (int i = 0; i < cyc; i++) begin
      if (i > 0) tick();
      we_m[i] = we_a;
      dw_m[i] = dwe_a;
      if (i == cyc - 1) ctl = {alu_a, bsel_a, dsel_a, rdst_a, wa_a};
    end
    tick();
  endtask

  logic [7:0]  we_m, dw_m;
  logic [10:0] ctl;

  initial begin
    for (int i = 0; i < 512; i++) imem_a[i] = 32'h0000_0000;
    for (int i = 0; i < 16; i++)  imem_b[i] = 32'h0800_000F;
    imem_a[0]     = 32'h0022_1820;  // ADD r3,r1,r2
    imem_a[1]     = 32'h8C05_0004;  // LW r5,4(r0)
    imem_a[2]     = 32'h1C22_FFFD;  // BGT r1,r2,-3
    imem_a[3]     = 32'hAC05_0008;  // SW r5,8(r0)
    imem_a[4]     = 32'h0800_000A;  // J 10
    imem_a[10]    = 32'h00E0_0008;  // JR r7
    imem_a[9'hA5] = 32'hF800_0000;  // opcode 3E, undefined
    imem_b[15]    = 32'h0022_1820;  // ADD at the top of a 16-word space

    rst = 1'b1; run = 1'b0; rd0 = 9'h0A5;
    cflag = 1'b0; nflag = 1'b0; vflag = 1'b0; zflag = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_val("rst_pc", pc_a, 0);
    check_val("rst_ret", ret_a, 0);
    check_val("rst_flags", {halted_a, ill_a, we_a, dwe_a, alu_a, bsel_a, dsel_a, rdst_a}, 0);

    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("idle_strobes", {we_a, dwe_a}, 0);
    end
    check_val("idle_pc", pc_a, 0);
    check_val("idle_ret", ret_a, 0);

    run = 1'b1;
    run_instr(4, we_m, dw_m, ctl);
    check_val("add_we", we_m, 8'b0000_1000);
    check_val("add_dw", dw_m, 8'h00);
    check_val("add_ctl", ctl, {3'b000, 1'b0, 1'b0, 1'b1, 5'd3});
    check_val("add_pc", pc_a, 1);
    check_val("add_ret", ret_a, 1);

    run_instr(5, we_m, dw_m, ctl);
    check_val("lw_we", we_m, 8'b0001_0000);
    check_val("lw_ctl", ctl, {3'b000, 1'b1, 1'b1, 1'b0, 5'd0});
    check_val("lw_pc", pc_a, 2);

    run_instr(3, we_m, dw_m, ctl);
    check_val("bgt_t_strobes", {we_m, dw_m}, 16'h0000);
    check_val("bgt_t_ctl", ctl, {3'b001, 1'b0, 1'b0, 1'b0, 5'd31});
    check_val("bgt_t_pc", pc_a, 0);
    check_val("bgt_t_ret", ret_a, 3);

    run_instr(4, we_m, dw_m, ctl);
    run_instr(5, we_m, dw_m, ctl);
    zflag = 1'b1;
    run_instr(3, we_m, dw_m, ctl);
    check_val("bgt_nt_pc", pc_a, 3);
    check_val("bgt_nt_ret", ret_a, 6);

    run_instr(4, we_m, dw_m, ctl);
    check_val("sw_dw", dw_m, 8'b0000_1000);
    check_val("sw_we", we_m, 8'h00);
    check_val("sw_ctl", ctl, {3'b000, 1'b1, 1'b0, 1'b0, 5'd0});
    check_val("sw_pc", pc_a, 4);

    run_instr(3, we_m, dw_m, ctl);
    check_val("j_pc", pc_a, 10);

    run_instr(3, we_m, dw_m, ctl);
    check_val("jr_pc", pc_a, 9'h0A5);
    check_val("jr_ret", ret_a, 9);

    repeat (2) tick();
    check_val("ill_halt", {halted_a, ill_a}, 2'b11);
    check_val("ill_pc", pc_a, 9'h0A5);
    repeat (5) tick();
    check_val("halt_hold", {pc_a, halted_a, we_a, dwe_a}, {9'h0A5, 1'b1, 1'b0, 1'b0});
    check_val("halt_ret", ret_a, 9);

    // Reset in the middle of an ADD writeback
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check_val("wb_we", we_a, 1);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_we", we_a, 0);
    check_val("mid_rst_pc", pc_a, 0);
    check_val("mid_rst_state", {halted_a, ill_a, ret_a}, 0);
    tick();
    rst = 1'b0;

    // Narrow instance: J 15, then ADD at pc=15 wraps to 0
    repeat (3) tick();
    check_val("b_j_pc", pc_b, 15);
    repeat (4) tick();
    check_val("b_wrap_pc", pc_b, 0);
    check_val("b_ret", ret_b, 2);
    repeat (120) tick();
    check_val("b_ret_sat", ret_b, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
